// File: rtl/apb_regfile_completer.sv
// APB3 completer that serves a small register file.
//
// A transfer takes one setup cycle plus one access cycle. WAIT_CYCLES wait states (pready low) are
// inserted in the access phase before the transfer completes.
//
// Register map:
//   RW registers at 4*k for k = 0 .. NUM_REGS-1
//   0x40 STATUS (read-only), returns status_i as sampled in the completing cycle
//   0x44 WRCNT  (read-only), returns {16'h0, count of committed legal writes}
//
// A transfer is illegal when any of these holds:
//   - the address is misaligned
//   - the address maps to nothing
//   - it writes to a read-only word
// An illegal transfer completes with pslverr set and changes no state.
//
// Ports:
//   pclk, preset       clock; synchronous active-high reset
//   psel, penable      APB select and access-phase strobe
//   pwrite, paddr      direction and byte address
//   pwdata, pstrb      write data and per-byte write strobes
//   prdata             read data; zero unless completing a legal read
//   pready, pslverr    transfer completion and error response
//   status_i           live status word mapped at 0x40
//   regs_o             flattened RW registers, reg k at [32k+31:32k]
module apb_regfile_completer #(
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [31:0]              paddr,
  input  logic [31:0]              pwdata,
  input  logic [3:0]               pstrb,
  output logic [31:0]              prdata,
  output logic                     pready,
  output logic                     pslverr,
  input  logic [31:0]              status_i,
  output logic [32*NUM_REGS-1:0]   regs_o
);

  localparam logic [31:0] StatusAddr = 32'h0000_0040;
  localparam logic [31:0] WrCntAddr  = 32'h0000_0044;
  localparam logic [31:0] RwLimit    = 32'(NUM_REGS * 4);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];
  logic [15:0] wr_count_q, wr_count_d;

  // Address decode from the bus values held during the access phase.
  logic        aligned;
  logic        is_rw;
  logic        is_status;
  logic        is_wrcnt;
  logic        legal;
  logic [3:0]  reg_idx;
  logic        commit;
  logic [31:0] rd_word;

  assign aligned   = (paddr[1:0] == 2'b00);
  assign is_rw     = aligned && (paddr < RwLimit);
  assign is_status = (paddr == StatusAddr);
  assign is_wrcnt  = (paddr == WrCntAddr);
  assign legal     = is_rw || (!pwrite && (is_status || is_wrcnt));
  assign reg_idx   = paddr[5:2];

  // pready is a pure function of state and wait counter.
  assign pready = (state_q == StAccess) && (cnt_q == 4'd0);
  assign commit = pready && psel && penable;

  // FSM next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        // An enable without a preceding setup cycle is ignored.
        if (psel && !penable) begin
          state_d = StAccess;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      StAccess: begin
        if (!psel) begin
          // Master abandoned the transfer; nothing is committed.
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (penable) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Register-file and write-counter updates.
  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_d[k] = regs_q[k];
    end
    wr_count_d = wr_count_q;
    if (commit && pwrite && legal) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (reg_idx == 4'(k)) begin
          for (int b = 0; b < 4; b++) begin
            if (pstrb[b]) begin
              regs_d[k][8*b +: 8] = pwdata[8*b +: 8];
            end
          end
        end
      end
      // A write with all strobes off is still a legal write and is counted.
      wr_count_d = wr_count_q + 16'd1;
    end
  end

  // Read mux.
  always_comb begin
    rd_word = 32'h0;
    if (is_status) begin
      rd_word = status_i;
    end else if (is_wrcnt) begin
      rd_word = {16'h0, wr_count_q};
    end else if (is_rw) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (reg_idx == 4'(k)) begin
          rd_word = regs_q[k];
        end
      end
    end
  end

  assign prdata  = (pready && !pwrite && legal) ? rd_word : 32'h0;
  assign pslverr = pready && !legal;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      wr_count_q <= 16'd0;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= RESET_VAL;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_count_q <= wr_count_d;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_o
    assign regs_o[32*k +: 32] = regs_q[k];
  end

endmodule

// File: tb/tb_apb_regfile_completer.sv
// Bench for apb_regfile_completer.
// DUT 0 has no wait states. DUT 1 has three wait states and a nonzero reset value.
// Stimulus tasks push the expected completion of every transfer into a per-DUT queue. A monitor
// pops one entry and compares it whenever a DUT completes a transfer.
module tb_apb_regfile_completer;

  localparam int unsigned    NR     = 4;
  localparam int unsigned    WC [2] = '{0, 3};
  localparam logic [31:0]    RV [2] = '{32'h0000_0000, 32'hA5A5_0F0F};

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              preset  [2];
  logic              psel    [2];
  logic              penable [2];
  logic              pwrite  [2];
  logic [31:0]       paddr   [2];
  logic [31:0]       pwdata  [2];
  logic [3:0]        pstrb   [2];
  logic [31:0]       prdata  [2];
  logic              pready  [2];
  logic              pslverr [2];
  logic [31:0]       status  [2];
  logic [32*NR-1:0]  regs_o  [2];

  apb_regfile_completer #(.NUM_REGS(NR), .WAIT_CYCLES(0), .RESET_VAL(32'h0000_0000)) u_dut0 (
    .pclk(clk), .preset(preset[0]), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]), .prdata(prdata[0]),
    .pready(pready[0]), .pslverr(pslverr[0]), .status_i(status[0]), .regs_o(regs_o[0])
  );

  apb_regfile_completer #(.NUM_REGS(NR), .WAIT_CYCLES(3), .RESET_VAL(32'hA5A5_0F0F)) u_dut1 (
    .pclk(clk), .preset(preset[1]), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]), .prdata(prdata[1]),
    .pready(pready[1]), .pslverr(pslverr[1]), .status_i(status[1]), .regs_o(regs_o[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model: register contents and write count per DUT.
  logic [31:0] m_regs  [2][NR];
  logic [15:0] m_wrcnt [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit m_legal(input bit wr, input logic [31:0] addr);
    if (addr % 4 != 0) return 1'b0;
    if (addr / 4 < NR) return 1'b1;
    return !wr && (addr == 32'h40 || addr == 32'h44);
  endfunction

  function automatic logic [31:0] m_read(input int d, input logic [31:0] addr);
    if (addr == 32'h40) return status[d];
    if (addr == 32'h44) return {16'h0, m_wrcnt[d]};
    return m_regs[d][addr / 4];
  endfunction

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic idle_bus(input int d);
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
    pwrite[d]  = 1'b0;
    paddr[d]   = 32'h0;
    pwdata[d]  = 32'h0;
    pstrb[d]   = 4'h0;
  endtask

  // Called and returning at posedge+1.
  task automatic do_reset(input int d);
    idle_bus(d);
    preset[d] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    preset[d] = 1'b0;
    for (int k = 0; k < NR; k++) m_regs[d][k] = RV[d];
    m_wrcnt[d] = 16'h0;
  endtask

  task automatic check_regs(input int d, input string tag);
    for (int k = 0; k < NR; k++) begin
      check($sformatf("%s_d%0d_reg%0d", tag, d, k), regs_o[d][32*k +: 32], m_regs[d][k]);
    end
  endtask

  // Full transfer: setup, access, wait for pready, return at posedge+1 after completion.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb);
    exp_t e;
    bit   lg;
    int   cycles;
    lg      = m_legal(wr, addr);
    e.err   = !lg;
    e.rdata = (!wr && lg) ? m_read(d, addr) : 32'h0;
    push(d, e);
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = wr;
    paddr[d]   = addr;
    pwdata[d]  = wdata;
    pstrb[d]   = strb;
    @(posedge clk);
    #1;
    penable[d] = 1'b1;
    cycles = 0;
    forever begin
      @(negedge clk);
      if (pready[d]) break;
      cycles++;
      if (cycles > 40) break;
    end
    check($sformatf("wait_states_d%0d", d), 32'(cycles), 32'(WC[d]));
    @(posedge clk);
    #1;
    idle_bus(d);
    if (wr && lg) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) m_regs[d][addr / 4][8*b +: 8] = wdata[8*b +: 8];
      end
      m_wrcnt[d] = m_wrcnt[d] + 16'h1;
    end
  endtask

  // Monitor: compare every completing transfer against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (!preset[d] && psel[d] && penable[d] && pready[d]) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_completion d%0d: got completion expected none", d);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("prdata_d%0d_a%h", d, paddr[d]), prdata[d], e.rdata);
          check($sformatf("pslverr_d%0d_a%h", d, paddr[d]), 32'(pslverr[d]), 32'(e.err));
        end
      end
    end
  end

  logic [31:0] addr_pool [10] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h40, 32'h44,
                                  32'h02, 32'h80, 32'h10, 32'h3C};

  initial begin
    for (int d = 0; d < 2; d++) begin
      idle_bus(d);
      preset[d] = 1'b0;
      status[d] = 32'h1234_5678 + 32'(d);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) do_reset(d);

    // Reset state.
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_prdata_d%0d", d), prdata[d], 32'h0);
      check($sformatf("rst_pready_d%0d", d), 32'(pready[d]), 32'h0);
      check($sformatf("rst_pslverr_d%0d", d), 32'(pslverr[d]), 32'h0);
      check_regs(d, "rst");
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) xfer(d, 1'b0, 32'h44, 32'h0, 4'h0);

    // Write then read back with no wait states.
    xfer(0, 1'b1, 32'h04, 32'hDEAD_BEEF, 4'hF);
    xfer(0, 1'b0, 32'h04, 32'h0, 4'h0);
    xfer(0, 1'b0, 32'h44, 32'h0, 4'h0);

    // Wait-state read.
    xfer(1, 1'b0, 32'h00, 32'h0, 4'h0);

    // Byte strobes, then a write with no strobes that must still be counted.
    for (int d = 0; d < 2; d++) begin
      xfer(d, 1'b1, 32'h00, 32'h1122_3344, 4'hF);
      xfer(d, 1'b1, 32'h00, 32'hAABB_CCDD, 4'b0101);
      xfer(d, 1'b0, 32'h00, 32'h0, 4'h0);
      xfer(d, 1'b1, 32'h08, 32'hFFFF_FFFF, 4'h0);
      xfer(d, 1'b0, 32'h44, 32'h0, 4'h0);
    end
    @(negedge clk);
    check("strobe_reg0", regs_o[0][31:0], 32'h11BB_33DD);
    @(posedge clk);
    #1;

    // Illegal accesses.
    for (int d = 0; d < 2; d++) begin
      xfer(d, 1'b1, 32'h40, 32'h0BAD_0BAD, 4'hF);
      xfer(d, 1'b0, 32'h02, 32'h0, 4'h0);
      xfer(d, 1'b0, 32'h80, 32'h0, 4'h0);
      xfer(d, 1'b1, 32'h06, 32'h0BAD_0BAD, 4'hF);
      xfer(d, 1'b0, 32'h44, 32'h0, 4'h0);
      xfer(d, 1'b0, 32'h40, 32'h0, 4'h0);
      @(negedge clk);
      check_regs(d, "err");
      @(posedge clk);
      #1;
    end

    // Abort mid-wait: drop psel during a wait state; nothing may be committed.
    psel[1]    = 1'b1;
    pwrite[1]  = 1'b1;
    paddr[1]   = 32'h0C;
    pwdata[1]  = 32'hCAFE_F00D;
    pstrb[1]   = 4'hF;
    @(posedge clk);
    #1;
    penable[1] = 1'b1;
    @(posedge clk);
    #1;
    idle_bus(1);
    @(posedge clk);
    #1;
    xfer(1, 1'b0, 32'h0C, 32'h0, 4'h0);
    xfer(1, 1'b0, 32'h44, 32'h0, 4'h0);

    // Reset asserted during the access phase of a write.
    psel[1]    = 1'b1;
    pwrite[1]  = 1'b1;
    paddr[1]   = 32'h08;
    pwdata[1]  = 32'h5555_AAAA;
    pstrb[1]   = 4'hF;
    @(posedge clk);
    #1;
    penable[1] = 1'b1;
    @(posedge clk);
    #1;
    preset[1] = 1'b1;
    @(posedge clk);
    #1;
    preset[1] = 1'b0;
    idle_bus(1);
    for (int k = 0; k < NR; k++) m_regs[1][k] = RV[1];
    m_wrcnt[1] = 16'h0;
    @(negedge clk);
    check_regs(1, "midrst");
    @(posedge clk);
    #1;
    xfer(1, 1'b0, 32'h44, 32'h0, 4'h0);
    xfer(1, 1'b1, 32'h08, 32'h0102_0304, 4'hF);
    xfer(1, 1'b0, 32'h08, 32'h0, 4'h0);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      for (int d = 0; d < 2; d++) begin
        status[d] = $urandom;
        xfer(d, 1'($urandom_range(0, 1)), addr_pool[$urandom_range(0, 9)], $urandom,
             4'($urandom_range(0, 15)));
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) check_regs(d, "final");

    check("q0_drained", 32'(q0.size()), 32'h0);
    check("q1_drained", 32'(q1.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
